// File: rtl/ram_share_ctrl_pkg.sv
// Shared constants for ram_share_ctrl.
// FSM state encoding and port-select values.
package ram_share_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/genericRAM.sv
// Single-port RAM with registered read address.
// Ports: clk, wren (write enable), addr, data (write data), q (read data).
module genericRAM #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (wren) begin
      r_mem[addr] <= data;
    end
    r_addr <= addr;
  end

  // Read-after-write on consecutive cycles sees the new word.
  assign q = r_mem[r_addr];

endmodule

// File: rtl/ram_share_ctrl.sv
// Shares one genericRAM between ports A and B: zero-fill after
// reset, then one round-robin grant per cycle, 1-cycle read latency.
// Ports: clk, resetn (async low); per port x in {a,b}: req_x, we_x,
// addr_x, wdata_x in; gnt_x, rvalid_x, rdata_x out; busy out.
module ram_share_ctrl
  import ram_share_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last;
  logic              r_rvalid_a;
  logic              r_rvalid_b;

  logic              w_pick_a;
  logic              w_pick_b;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_data;
  logic [DATA_W-1:0] w_ram_q;

  // Mutually exclusive: on contention the port not served last wins.
  assign w_pick_a = req_a & (~req_b | (r_last == PORT_B));
  assign w_pick_b = req_b & (~req_a | (r_last == PORT_A));

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_last_addr;
    w_ram_data  = '0;
    unique case (r_state)
      CLEAR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr_addr;
        if (&r_clr_addr) begin
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        unique case (1'b1)
          w_pick_a: begin
            w_gnt_a    = 1'b1;
            w_ram_we   = we_a;
            w_ram_addr = addr_a;
            w_ram_data = wdata_a;
          end
          w_pick_b: begin
            w_gnt_b    = 1'b1;
            w_ram_we   = we_b;
            w_ram_addr = addr_b;
            w_ram_data = wdata_b;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= CLEAR;
      r_clr_addr  <= '0;
      r_last_addr <= '0;
      r_last      <= PORT_B;
      r_rvalid_a  <= 1'b0;
      r_rvalid_b  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rvalid_a <= w_gnt_a & ~we_a;
      r_rvalid_b <= w_gnt_b & ~we_b;
      if (r_state == CLEAR) begin
        r_clr_addr <= r_clr_addr + ONE;
      end
      if (w_gnt_a) begin
        r_last      <= PORT_A;
        r_last_addr <= addr_a;
      end
      if (w_gnt_b) begin
        r_last      <= PORT_B;
        r_last_addr <= addr_b;
      end
    end
  end

  genericRAM #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk (clk),
    .wren(w_ram_we),
    .addr(w_ram_addr),
    .data(w_ram_data),
    .q   (w_ram_q)
  );

  assign gnt_a    = w_gnt_a;
  assign gnt_b    = w_gnt_b;
  assign busy     = (r_state == CLEAR);
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata_a  = r_rvalid_a ? w_ram_q : '0;
  assign rdata_b  = r_rvalid_b ? w_ram_q : '0;

endmodule

// File: tb/tb_ram_share_ctrl.sv
// Testbench for ram_share_ctrl: directed scenarios plus random
// traffic checked against a behavioural memory/arbiter model.
module tb_ram_share_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [DW-1:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  ram_share_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: memory image, clear cycles left, last winner (0=A,1=B),
  // this cycle's predicted grants, and pending read results.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr_left;
  bit            m_last;
  bit            m_ga, m_gb, m_rva, m_rvb;
  logic [DW-1:0] m_rda, m_rdb;

  task automatic idle_inputs();
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic model_reset();
    m_clr_left = DEPTH;
    m_last = 1'b1;
    m_ga = 0; m_gb = 0; m_rva = 0; m_rvb = 0;
  endtask

  // Move to mid-cycle and predict this cycle's grants.
  task automatic settle();
    @(negedge clk);
    m_ga = 0; m_gb = 0;
    if (m_clr_left == 0) begin
      if (req_a && req_b) begin
        if (m_last) m_ga = 1; else m_gb = 1;
      end else begin
        m_ga = req_a;
        m_gb = req_b;
      end
    end
  endtask

  // Apply the clock edge to the model.
  task automatic edge_();
    @(posedge clk);
    if (m_clr_left > 0) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
      m_rva = 0; m_rvb = 0;
    end else begin
      m_rva = m_ga && !we_a;
      m_rvb = m_gb && !we_b;
      m_rda = m_mem[addr_a];
      m_rdb = m_mem[addr_b];
      if (m_ga && we_a) m_mem[addr_a] = wdata_a;
      if (m_gb && we_b) m_mem[addr_b] = wdata_b;
      if (m_ga) m_last = 0;
      if (m_gb) m_last = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] ea;
    idle_inputs();
    req_a = 1; req_b = 1;
    resetn = 0;
    model_reset();
    #2;
    n_checks++;
    if ({busy, gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b}
        !== {1'b1, 4'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_outs got %b exp busy=1 rest 0",
               {busy, gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b});
    end
    idle_inputs();
    @(posedge clk); #1 resetn = 1;
    for (int c = 0; c < DEPTH; c++) begin
      settle();
      ea = AW'(c);
      n_checks++;
      if ({busy, dut.w_ram_we, dut.w_ram_addr} !== {2'b11, ea}) begin
        n_fail++;
        $display("FAIL clear_cyc%0d got busy=%b we=%b addr=%0d exp 1 1 %0d",
                 c, busy, dut.w_ram_we, dut.w_ram_addr, ea);
      end
      edge_();
    end
    settle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_clear got %b exp 0", busy);
    end
    edge_();
  endtask

  task automatic test_contention();
    req_a = 1; we_a = 0; addr_a = 5'd3;
    req_b = 1; we_b = 1; addr_b = 5'd7; wdata_b = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_checks++;
      if ({gnt_a, gnt_b} !== {k % 2 == 0, k % 2 == 1}) begin
        n_fail++;
        $display("FAIL alt_gnt k=%0d got %b%b exp %b%b", k, gnt_a, gnt_b,
                 k % 2 == 0, k % 2 == 1);
      end
      n_checks++;
      if ({rvalid_a, rdata_a, rvalid_b} !==
          {m_rva, m_rva ? m_rda : 8'h0, m_rvb}) begin
        n_fail++;
        $display("FAIL alt_rd k=%0d got %b %h %b exp %b %h %b", k,
                 rvalid_a, rdata_a, rvalid_b, m_rva, m_rda, m_rvb);
      end
      edge_();
    end
    idle_inputs();
    req_a = 1; addr_a = 5'd7;
    settle(); edge_();
    idle_inputs();
    settle();
    n_checks++;
    if ({rvalid_a, rdata_a} !== {1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL contention_store got %b %h exp 1 5a", rvalid_a, rdata_a);
    end
    edge_();
  endtask

  task automatic test_fill_a();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      req_a = 1; we_a = 1; addr_a = AW'(i); wdata_a = DW'(i);
      settle();
      n_checks++;
      if ({gnt_a, gnt_b} !== 2'b10) begin
        n_fail++;
        $display("FAIL fill_wr_gnt i=%0d got %b%b exp 10", i, gnt_a, gnt_b);
      end
      edge_();
    end
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin
        req_a = 1; we_a = 0; addr_a = AW'(i);
      end else begin
        idle_inputs();
      end
      settle();
      n_checks++;
      if (gnt_a !== (i < DEPTH)) begin
        n_fail++;
        $display("FAIL fill_rd_gnt i=%0d got %b", i, gnt_a);
      end
      if (i > 0) begin
        n_checks++;
        if ({rvalid_a, rdata_a} !== {1'b1, DW'(i - 1)}) begin
          n_fail++;
          $display("FAIL fill_rd i=%0d got %b %h exp 1 %h", i, rvalid_a,
                   rdata_a, DW'(i - 1));
        end
      end
      edge_();
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    req_b = 1; we_b = 1; addr_b = 5'd9; wdata_b = 8'hC3;
    settle();
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_b_gnt got %b%b exp 01", gnt_a, gnt_b);
    end
    edge_();
    idle_inputs();
    req_a = 1; addr_a = 5'd9;
    settle();
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL rd_a_gnt got %b%b exp 10", gnt_a, gnt_b);
    end
    edge_();
    idle_inputs();
    settle();
    n_checks++;
    if ({rvalid_a, rdata_a, rvalid_b} !== {1'b1, 8'hC3, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_then_rd got %b %h %b exp 1 c3 0", rvalid_a,
               rdata_a, rvalid_b);
    end
    edge_();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 300; c++) begin
      // A port still waiting for its grant keeps its request stable.
      if (!(req_a && !m_ga)) begin
        req_a   = ($urandom_range(0, 3) != 0);
        we_a    = $urandom_range(0, 1) == 1;
        addr_a  = AW'($urandom_range(0, 7));
        wdata_a = DW'($urandom);
      end
      if (!(req_b && !m_gb)) begin
        req_b   = ($urandom_range(0, 3) != 0);
        we_b    = $urandom_range(0, 1) == 1;
        addr_b  = AW'($urandom_range(0, 7));
        wdata_b = DW'($urandom);
      end
      settle();
      n_checks++;
      if ({gnt_a, gnt_b, busy} !== {m_ga, m_gb, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd_gnt c=%0d got %b%b%b exp %b%b0", c, gnt_a,
                 gnt_b, busy, m_ga, m_gb);
      end
      n_checks++;
      if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !==
          {m_rva, m_rva ? m_rda : 8'h0, m_rvb, m_rvb ? m_rdb : 8'h0}) begin
        n_fail++;
        $display("FAIL rnd_rd c=%0d got %b %h %b %h exp %b %h %b %h", c,
                 rvalid_a, rdata_a, rvalid_b, rdata_b,
                 m_rva, m_rda, m_rvb, m_rdb);
      end
      edge_();
    end
    idle_inputs();
    settle(); edge_();
  endtask

  task automatic test_clear_request();
    idle_inputs();
    resetn = 0;
    model_reset();
    @(posedge clk); #1 resetn = 1;
    for (int c = 0; c <= DEPTH; c++) begin
      if (c == 5) begin
        req_a = 1; we_a = 0; addr_a = 5'd4;
      end
      settle();
      n_checks++;
      if ({busy, gnt_a} !== {c < DEPTH, c == DEPTH}) begin
        n_fail++;
        $display("FAIL clr_req c=%0d got busy=%b gnt_a=%b", c, busy, gnt_a);
      end
      edge_();
    end
    idle_inputs();
    settle();
    n_checks++;
    if ({rvalid_a, rdata_a} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL clr_req_rd got %b %h exp 1 00", rvalid_a, rdata_a);
    end
    edge_();
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    resetn = 0;
    model_reset();
    @(posedge clk); #1 resetn = 1;
    for (int c = 0; c < 12; c++) begin
      settle(); edge_();
    end
    settle();
    n_checks++;
    if (dut.w_ram_addr !== 5'd12) begin
      n_fail++;
      $display("FAIL mid_clr_addr got %0d exp 12", dut.w_ram_addr);
    end
    #2 resetn = 0;
    model_reset();
    #1;
    n_checks++;
    if ({busy, gnt_a, gnt_b, rvalid_a, rvalid_b, dut.w_ram_addr} !==
        {1'b1, 4'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL mid_clr_reset got busy=%b gnt=%b%b rv=%b%b addr=%0d",
               busy, gnt_a, gnt_b, rvalid_a, rvalid_b, dut.w_ram_addr);
    end
    @(posedge clk); #1 resetn = 1;
    for (int c = 0; c <= DEPTH; c++) begin
      settle();
      n_checks++;
      if ({busy, dut.w_ram_addr} !== {c < DEPTH, AW'(c)}) begin
        n_fail++;
        $display("FAIL restart_clr c=%0d got busy=%b addr=%0d", c, busy,
                 dut.w_ram_addr);
      end
      edge_();
    end
    req_a = 1; we_a = 0; addr_a = 5'd2;
    settle();
    edge_();
    idle_inputs();
    resetn = 0;
    model_reset();
    #1;
    n_checks++;
    if ({rvalid_a, rdata_a, busy} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_drop got rv=%b rd=%h busy=%b exp 0 00 1", rvalid_a,
               rdata_a, busy);
    end
    @(posedge clk); #1 resetn = 1;
    for (int c = 0; c < DEPTH; c++) begin
      settle();
      n_checks++;
      if ({rvalid_a, rvalid_b, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL clr_no_rv c=%0d got %b%b%b exp 001", c, rvalid_a,
                 rvalid_b, busy);
      end
      edge_();
    end
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        req_b = 1; we_b = 0; addr_b = AW'(i);
      end else begin
        idle_inputs();
      end
      settle();
      if (i > 0) begin
        n_checks++;
        if ({rvalid_b, rdata_b} !== {1'b1, 8'h00} ||
            {rvalid_b, rdata_b} !== {m_rvb, m_rdb}) begin
          n_fail++;
          $display("FAIL zero_rd i=%0d got %b %h exp 1 00", i, rvalid_b,
                   rdata_b);
        end
      end
      edge_();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_contention();
    test_fill_a();
    test_write_read();
    test_random();
    test_clear_request();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
